counter_nbit_updown: RTL and testbench

COUNTER_NBIT_UPDOWN -- requirements
Module: counter_nbit_updown

---
 rtl/counter_pkg.sv | 18 +
 rtl/counter_step.sv | 74 +++++++
 rtl/counter_nbit_updown.sv | 102 ++++++++++
 tb/tb_counter_nbit_updown.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared encodings for the up/down counter.
//   mode_t  : counting mode selected by the 2-bit mode input
//   state_t : one-shot FSM state
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11   // treated as wrap
    } mode_t;

    typedef enum logic {
        ST_COUNTING = 1'b0,
        ST_DONE     = 1'b1
    } state_t;

endpackage

// File: rtl/counter_step.sv
// Combinational next-value and limit-hit computation for one enabled step.
// Ports:
//   count      in  WIDTH  current count
//   up         in  1      1 = step up, 0 = step down
//   mode       in  2      counting mode (counter_pkg::mode_t encoding)
//   next_value out WIDTH  count after this step
//   terminal   out 1      this step wraps, or first reaches a saturating limit
//   at_limit   out 1      saturating/one-shot result sits on the limit in the step direction
module counter_step
    import counter_pkg::*;
#(
    parameter int WIDTH     = 10,
    parameter int INCREMENT = 1,
    parameter int MAX_VALUE = (2**WIDTH) - 1,
    parameter int MIN_VALUE = 0
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] next_value,
    output logic             terminal,
    output logic             at_limit
);

    localparam logic [WIDTH:0]   INC_EXT = (WIDTH+1)'(INCREMENT);
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VALUE);
    localparam logic [WIDTH:0]   MIN_EXT = (WIDTH+1)'(MIN_VALUE);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_VALUE);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           over;
    logic           under;

    always_comb begin
        // One extra bit keeps the sum exact; the difference is read as signed,
        // which covers both a borrow past zero and a dip below MIN_VALUE.
        sum   = {1'b0, count} + INC_EXT;
        diff  = {1'b0, count} - INC_EXT;
        over  = sum > MAX_EXT;
        under = $signed(diff) < $signed(MIN_EXT);

        next_value = count;
        terminal   = 1'b0;
        at_limit   = 1'b0;

        case (mode)
            MODE_SAT, MODE_ONESHOT: begin
                if (up) begin
                    next_value = over ? MAX_W : sum[WIDTH-1:0];
                    at_limit   = (next_value == MAX_W);
                    // Saturate pulses only on arrival; one-shot pulses whenever
                    // it lands on the limit since that step also ends the run.
                    terminal   = at_limit && ((mode == MODE_ONESHOT) || (count != MAX_W));
                end else begin
                    next_value = under ? MIN_W : diff[WIDTH-1:0];
                    at_limit   = (next_value == MIN_W);
                    terminal   = at_limit && ((mode == MODE_ONESHOT) || (count != MIN_W));
                end
            end
            default: begin
                if (up) begin
                    next_value = over ? MIN_W : sum[WIDTH-1:0];
                    terminal   = over;
                end else begin
                    next_value = under ? MAX_W : diff[WIDTH-1:0];
                    terminal   = under;
                end
            end
        endcase
    end

endmodule

// File: rtl/counter_nbit_updown.sv
// N-bit up/down counter with wrap, saturate and one-shot modes.
// Ports:
//   clock      in  1      rising-edge clock
//   reset      in  1      synchronous active-high reset
//   enable     in  1      advance one step this cycle
//   up         in  1      1 = count up, 0 = count down
//   load       in  1      load loadValue (clamped to limits) this cycle
//   loadValue  in  WIDTH  value to load
//   mode       in  2      00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   countValue out WIDTH  current count
//   terminal   out 1      registered one-cycle pulse on reaching/crossing a limit
//   done       out 1      registered, high while the one-shot has completed
//
// state       | meaning
// ST_COUNTING | enabled cycles step the count
// ST_DONE     | one-shot finished; count held until load or reset
module counter_nbit_updown
    import counter_pkg::*;
#(
    parameter int WIDTH     = 10,
    parameter int INCREMENT = 1,
    parameter int MAX_VALUE = (2**WIDTH) - 1,
    parameter int MIN_VALUE = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] loadValue,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] countValue,
    output logic             terminal,
    output logic             done
);

    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VALUE);
    localparam logic [WIDTH:0]   MIN_EXT = (WIDTH+1)'(MIN_VALUE);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_VALUE);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] next_count;
    logic             next_terminal;

    logic [WIDTH-1:0] step_value;
    logic             step_terminal;
    logic             step_at_limit;

    counter_step #(
        .WIDTH     (WIDTH),
        .INCREMENT (INCREMENT),
        .MAX_VALUE (MAX_VALUE),
        .MIN_VALUE (MIN_VALUE)
    ) u_step (
        .count      (countValue),
        .up         (up),
        .mode       (mode),
        .next_value (step_value),
        .terminal   (step_terminal),
        .at_limit   (step_at_limit)
    );

    always_comb begin
        next_state    = state;
        next_count    = countValue;
        next_terminal = 1'b0;

        if (load) begin
            if ({1'b0, loadValue} > MAX_EXT) begin
                next_count = MAX_W;
            end else if ($signed({1'b0, loadValue}) < $signed(MIN_EXT)) begin
                next_count = MIN_W;
            end else begin
                next_count = loadValue;
            end
            next_state = ST_COUNTING;
        end else if (enable && (state == ST_COUNTING)) begin
            next_count    = step_value;
            next_terminal = step_terminal;
            if ((mode == MODE_ONESHOT) && step_at_limit) begin
                next_state = ST_DONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_COUNTING;
            countValue <= MIN_W;
            terminal   <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= next_state;
            countValue <= next_count;
            terminal   <= next_terminal;
            done       <= (next_state == ST_DONE);
        end
    end

endmodule

// File: tb/tb_counter_nbit_updown.sv
module tb_counter_nbit_updown;

    localparam int W    = 4;
    localparam int INC  = 3;
    localparam int MAXV = 13;
    localparam int MINV = 0;

    logic         clock = 1'b0;
    logic         reset;
    logic         enable;
    logic         up;
    logic         load;
    logic [W-1:0] loadValue;
    logic [1:0]   mode;
    logic [W-1:0] countValue;
    logic         terminal;
    logic         done;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int m_count;
    int m_term;
    int m_done;

    counter_nbit_updown #(
        .WIDTH     (W),
        .INCREMENT (INC),
        .MAX_VALUE (MAXV),
        .MIN_VALUE (MINV)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .up         (up),
        .load       (load),
        .loadValue  (loadValue),
        .mode       (mode),
        .countValue (countValue),
        .terminal   (terminal),
        .done       (done)
    );

    always #5 clock = ~clock;

    // Behavioural model: applies the counting rules with plain integer arithmetic.
    task automatic model_edge();
        int n;
        int m;
        int lim;
        if (reset) begin
            m_count = MINV; m_term = 0; m_done = 0;
        end else if (load) begin
            n = int'(loadValue);
            if (n > MAXV) n = MAXV;
            if (n < MINV) n = MINV;
            m_count = n; m_term = 0; m_done = 0;
        end else if (enable && m_done == 0) begin
            m = int'(mode);
            if (m == 3) m = 0;
            n = up ? m_count + INC : m_count - INC;
            if (m == 0) begin
                m_term = 0;
                if (n > MAXV) begin
                    m_count = MINV; m_term = 1;
                end else if (n < MINV) begin
                    m_count = MAXV; m_term = 1;
                end else begin
                    m_count = n;
                end
            end else begin
                lim = up ? MAXV : MINV;
                if (n > MAXV) n = MAXV;
                if (n < MINV) n = MINV;
                if (m == 1) begin
                    m_term = (n == lim && m_count != lim) ? 1 : 0;
                end else begin
                    m_term = (n == lim) ? 1 : 0;
                    if (n == lim) m_done = 1;
                end
                m_count = n;
            end
        end else begin
            m_term = 0;
        end
    endtask

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One clock edge: update the model, then sample #1 after the edge.
    task automatic tick(input string tag);
        model_edge();
        @(posedge clock);
        #1;
        check({tag, ".count"},    int'(countValue), m_count);
        check({tag, ".terminal"}, int'(terminal),   m_term);
        check({tag, ".done"},     int'(done),       m_done);
    endtask

    task automatic drive(input logic r, input logic e, input logic u,
                         input logic l, input int lv, input int md);
        reset = r; enable = e; up = u; load = l;
        loadValue = W'(lv); mode = 2'(md);
    endtask

    initial begin
        int exp_wrap [6];
        int exp_sat  [4];
        int exp_os   [4];
        exp_wrap = '{3, 6, 9, 12, 0, 3};
        exp_sat  = '{2, 0, 0, 0};
        exp_os   = '{10, 13, 13, 13};

        drive(1, 0, 1, 0, 0, 0);
        tick("reset");
        check("reset.lit_count", int'(countValue), 0);

        // wrap up from 0
        drive(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tick("wrap_up");
            check("wrap_up.lit_count", int'(countValue), exp_wrap[i]);
            check("wrap_up.lit_term",  int'(terminal),   (i == 4) ? 1 : 0);
        end

        // wrap down across zero
        drive(0, 1, 0, 0, 0, 0);
        tick("wrap_dn");
        check("wrap_dn.lit_count", int'(countValue), 0);
        tick("wrap_dn");
        check("wrap_dn.lit_count2", int'(countValue), 13);
        check("wrap_dn.lit_term",   int'(terminal),   1);

        // saturate down from 5
        drive(0, 0, 0, 1, 5, 1);
        tick("sat_load");
        drive(0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            tick("sat_dn");
            check("sat_dn.lit_count", int'(countValue), exp_sat[i]);
            check("sat_dn.lit_term",  int'(terminal),   (i == 1) ? 1 : 0);
        end

        // saturate up holding at MAX
        drive(0, 1, 1, 0, 0, 1);
        for (int i = 0; i < 6; i++) tick("sat_up");
        check("sat_up.lit_count", int'(countValue), 13);
        check("sat_up.lit_term",  int'(terminal),   0);

        // one-shot up from 7
        drive(0, 0, 1, 1, 7, 2);
        tick("os_load");
        drive(0, 1, 1, 0, 0, 2);
        for (int i = 0; i < 4; i++) begin
            tick("os_up");
            check("os_up.lit_count", int'(countValue), exp_os[i]);
            check("os_up.lit_term",  int'(terminal),   (i == 1) ? 1 : 0);
            check("os_up.lit_done",  int'(done),       (i >= 1) ? 1 : 0);
        end
        // mode change while done keeps it done
        drive(0, 1, 0, 0, 0, 0);
        tick("os_modechg");
        check("os_modechg.lit_done", int'(done), 1);
        drive(0, 0, 1, 1, 2, 2);
        tick("os_reload");
        check("os_reload.lit_count", int'(countValue), 2);
        check("os_reload.lit_done",  int'(done),       0);

        // load+enable with out-of-range value clamps, no step
        drive(0, 1, 1, 1, 15, 0);
        tick("load_clamp");
        check("load_clamp.lit_count", int'(countValue), 13);
        check("load_clamp.lit_term",  int'(terminal),   0);

        // reset at count 9 while enabled
        drive(0, 0, 1, 1, 9, 0);
        tick("pre_rst");
        drive(1, 1, 1, 0, 0, 0);
        tick("rst_mid");
        check("rst_mid.lit_count", int'(countValue), 0);
        check("rst_mid.lit_term",  int'(terminal),   0);

        // reset while in DONE
        drive(0, 0, 1, 1, 12, 2);
        tick("os2_load");
        drive(0, 1, 1, 0, 0, 2);
        tick("os2_up");
        check("os2_up.lit_done", int'(done), 1);
        drive(1, 1, 1, 0, 0, 2);
        tick("rst_done");
        check("rst_done.lit_done", int'(done), 0);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0),
                  int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 3)));
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
